// File: rtl/noc_bridge_narrow_wide_pkg.sv
// Shared types for the narrow/wide NoC bridge receive path.
//   channel_hdr_e   : channel index carried in the AXIS beat header
//   HdrW            : width of channel_hdr_e
//   AxisDataW       : default AXIS tdata width (header + 64-bit flit + spare)
//   axis_in_req_t   : default AXIS request (tvalid + t.data)
//   axis_in_rsp_t   : default AXIS response (tready)
package noc_bridge_narrow_wide_pkg;

  localparam int unsigned HdrW      = 1;
  localparam int unsigned AxisDataW = 72;

  typedef enum logic [HdrW-1:0] {
    request  = 1'b0,
    response = 1'b1
  } channel_hdr_e;

  typedef struct packed {
    logic [AxisDataW-1:0] data;
  } axis_t_t;

  typedef struct packed {
    logic    tvalid;
    axis_t_t t;
  } axis_in_req_t;

  typedef struct packed {
    logic tready;
  } axis_in_rsp_t;

endpackage

// File: rtl/floo_axis_rx_chan.sv
// One receive channel: a Depth-entry FIFO (registered output, no fall-through,
// no full pass-through) plus an optional credit-return register.
// Optional feature macro: FLOO_AXIS_RX_CREDIT_EN (registered credit pulse).
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/data_i : write strobe (caller guarantees !full_o) and flit data
//   full_o        : FIFO full
//   valid_o/ready_i/data_o : flit output handshake, data zero while empty
//   credit_o      : one-cycle pulse the cycle after each pop
module floo_axis_rx_chan #(
  parameter int unsigned DataW = 64,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [DataW-1:0] data_i,
  output logic             full_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [DataW-1:0] data_o,
  output logic             credit_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [DataW-1:0] r_mem [Depth];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [PtrW:0]    r_wptr;
  logic [PtrW:0]    r_rptr;
  logic             w_empty;
  logic             w_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                   (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
  assign valid_o = !w_empty;
  assign w_pop   = valid_o & ready_i;
  // Storage is not reset; gating keeps the output at zero while empty.
  assign data_o  = w_empty ? '0 : r_mem[r_rptr[PtrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + {{PtrW{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{PtrW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr[PtrW-1:0]] <= data_i;
  end

`ifdef FLOO_AXIS_RX_CREDIT_EN
  logic r_credit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_credit <= 1'b0;
    else         r_credit <= w_pop;
  end

  assign credit_o = r_credit;
`else
  assign credit_o = 1'b0;
`endif

endmodule

// File: rtl/floo_axis_rx_demux.sv
// Receive-side demux: steers tagged AXIS beats {channel header, flit data}
// into per-channel FIFOs so a stalled NoC channel does not block others.
// Optional feature macro: FLOO_AXIS_RX_CREDIT_EN (per-pop credit pulses).
// Ports:
//   clk_i, rst_ni   : clock, async active-low reset
//   axis_in_req_i   : incoming beat (tvalid, t.data)
//   axis_in_rsp_o   : tready (header + FIFO full only, never flit_ready_i)
//   flit_valid_o/flit_ready_i/flit_data_o : per-channel flit outputs
//   credit_o        : per-channel credit-return pulse
//   hdr_err_o       : sticky illegal-header flag
//   hdr_err_cnt_o   : saturating count of dropped beats
module floo_axis_rx_demux
  import noc_bridge_narrow_wide_pkg::*;
#(
  parameter int unsigned NumChan   = 2,
  parameter int unsigned FlitDataW = 64,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned ErrCntW   = 8,
  parameter type axis_req_t = noc_bridge_narrow_wide_pkg::axis_in_req_t,
  parameter type axis_rsp_t = noc_bridge_narrow_wide_pkg::axis_in_rsp_t
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  axis_req_t                         axis_in_req_i,
  output axis_rsp_t                         axis_in_rsp_o,
  output logic [NumChan-1:0]                flit_valid_o,
  input  logic [NumChan-1:0]                flit_ready_i,
  output logic [NumChan-1:0][FlitDataW-1:0] flit_data_o,
  output logic [NumChan-1:0]                credit_o,
  output logic                              hdr_err_o,
  output logic [ErrCntW-1:0]                hdr_err_cnt_o
);

  localparam int unsigned IdxW = $clog2(NumChan);

  logic [IdxW-1:0]    w_hdr;
  logic               w_hdr_legal;
  logic               w_tready;
  logic               w_drop;
  logic [NumChan-1:0] w_full;
  logic [NumChan-1:0] w_push;
  logic               r_hdr_err;
  logic [ErrCntW-1:0] r_err_cnt;
  logic               w_unused;

  // Upper tdata bits and the other AXIS sideband fields are don't-care.
  assign w_unused    = ^axis_in_req_i;

  assign w_hdr       = axis_in_req_i.t.data[IdxW+FlitDataW-1 -: IdxW];
  assign w_hdr_legal = ({{(32-IdxW){1'b0}}, w_hdr} < NumChan);

  always_comb begin
    w_tready = 1'b1;
    w_push   = '0;
    if (w_hdr_legal) begin
      w_tready       = !w_full[w_hdr];
      w_push[w_hdr]  = axis_in_req_i.tvalid & w_tready;
    end
  end

  always_comb begin
    axis_in_rsp_o        = '0;
    axis_in_rsp_o.tready = w_tready;
  end

  assign w_drop = axis_in_req_i.tvalid & !w_hdr_legal;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hdr_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_drop) begin
      r_hdr_err <= 1'b1;
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + {{(ErrCntW-1){1'b0}}, 1'b1};
    end
  end

  assign hdr_err_o     = r_hdr_err;
  assign hdr_err_cnt_o = r_err_cnt;

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    floo_axis_rx_chan #(
      .DataW (FlitDataW),
      .Depth (FifoDepth)
    ) i_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .push_i   (w_push[c]),
      .data_i   (axis_in_req_i.t.data[FlitDataW-1:0]),
      .full_o   (w_full[c]),
      .valid_o  (flit_valid_o[c]),
      .ready_i  (flit_ready_i[c]),
      .data_o   (flit_data_o[c]),
      .credit_o (credit_o[c])
    );
  end

endmodule

// File: tb/tb_floo_axis_rx_demux.sv
module tb_floo_axis_rx_demux;
  import noc_bridge_narrow_wide_pkg::*;

`ifdef FLOO_AXIS_RX_CREDIT_EN
  localparam bit CR = 1'b1;
`else
  localparam bit CR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Two-channel instance (power-of-two, no illegal headers possible)
  axis_in_req_t      req0;
  axis_in_rsp_t      rsp0;
  logic [1:0]        v0, rdy0, cr0;
  logic [1:0][63:0]  data0;
  logic              err0;
  logic [7:0]        cnt0;

  // Three-channel instance (header 3 is illegal)
  axis_in_req_t      req1;
  axis_in_rsp_t      rsp1;
  logic [2:0]        v1, rdy1, cr1;
  logic [2:0][63:0]  data1;
  logic              err1;
  logic [7:0]        cnt1;

  floo_axis_rx_demux #(.NumChan(2), .FlitDataW(64), .FifoDepth(4), .ErrCntW(8)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .axis_in_req_i(req0), .axis_in_rsp_o(rsp0),
    .flit_valid_o(v0), .flit_ready_i(rdy0), .flit_data_o(data0), .credit_o(cr0),
    .hdr_err_o(err0), .hdr_err_cnt_o(cnt0));

  floo_axis_rx_demux #(.NumChan(3), .FlitDataW(64), .FifoDepth(4), .ErrCntW(8)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .axis_in_req_i(req1), .axis_in_rsp_o(rsp1),
    .flit_valid_o(v1), .flit_ready_i(rdy1), .flit_data_o(data1), .credit_o(cr1),
    .hdr_err_o(err1), .hdr_err_cnt_o(cnt1));

  int n_vec = 0;
  int n_err = 0;
  int n_cred = 0;
  int n_pop = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic axis_in_req_t beat(input logic [1:0] hdr, input logic [63:0] d);
    axis_in_req_t r;
    r = '0;
    r.tvalid = 1'b1;
    r.t.data[65:64] = hdr;
    r.t.data[63:0]  = d;
    return r;
  endfunction

  always @(negedge clk) if (rst_n) n_cred += $countones(cr0);

  logic [63:0] q [2][$];

  initial begin
    req0 = '0; req1 = '0; rdy0 = '0; rdy1 = '0;
    // ---------------- reset state
    tick(); tick();
    check("rst_valid", 64'(v0), 0);
    check("rst_data", data0[0] | data0[1], 0);
    check("rst_credit", 64'(cr0), 0);
    check("rst_err", 64'(err1), 0);
    check("rst_cnt", 64'(cnt1), 0);
    req0 = beat(request, 64'h1); req0.tvalid = 1'b0;
    #1 check("rst_tready", 64'(rsp0.tready), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- single beat, latency and credit
    rdy0 = 2'b11;
    req0 = beat(request, 64'hA5);
    #1 check("t1_tready", 64'(rsp0.tready), 1);
    check("t1_no_fallthru", 64'(v0), 0);
    tick();
    req0.tvalid = 1'b0;
    check("t1_valid", 64'(v0), 2'b01);
    check("t1_data", data0[0], 64'hA5);
    check("t1_cr_early", 64'(cr0), 0);
    tick();
    check("t1_popped", 64'(v0), 0);
    check("t1_credit", 64'(cr0), {63'd0, CR});
    tick();
    check("t1_cr_single", 64'(cr0), 0);

    // ---------------- fill ch0, beat to ch1, blocked ch0 beat
    rdy0 = 2'b00;
    for (int i = 0; i < 4; i++) begin
      req0 = beat(request, 64'h10 + 64'(i));
      #1 check("t2_fill_tready", 64'(rsp0.tready), 1);
      tick();
    end
    req0 = beat(response, 64'h20);
    #1 check("t2_ch1_tready", 64'(rsp0.tready), 1);
    tick();
    check("t2_ch1_valid", 64'(v0[1]), 1);
    check("t2_ch1_data", data0[1], 64'h20);
    req0 = beat(request, 64'h14);
    #1 check("t2_full_tready", 64'(rsp0.tready), 0);
    tick();
    check("t2_full_hold", 64'(rsp0.tready), 0);

    // ---------------- release ch0 while its beat is pending
    rdy0 = 2'b01;
    #1 check("t3_no_passthru", 64'(rsp0.tready), 0);
    check("t3_head0", data0[0], 64'h10);
    tick();
    check("t3_tready_next", 64'(rsp0.tready), 1);
    check("t3_head1", data0[0], 64'h11);
    tick();
    req0.tvalid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      check("t3_order", data0[0], 64'h10 + 64'(i));
      tick();
    end
    check("t3_drained", 64'(v0[0]), 0);
    check("t3_ch1_stable", data0[1], 64'h20);
    check("t3_ch1_valid", 64'(v0[1]), 1);
    rdy0 = 2'b11;
    tick();
    check("t3_ch1_popped", 64'(v0[1]), 0);
    tick(); tick();

    // ---------------- illegal headers on the three-channel instance
    rdy1 = 3'b111;
    req1 = beat(2'd3, 64'h77);
    #1 check("t4_ill_tready", 64'(rsp1.tready), 1);
    tick();
    req1.tvalid = 1'b0;
    check("t4_ill_novalid", 64'(v1), 0);
    check("t4_ill_err", 64'(err1), 1);
    check("t4_ill_cnt1", 64'(cnt1), 1);
    req1 = beat(2'd2, 64'h55);
    tick();
    req1.tvalid = 1'b0;
    check("t4_ch2_valid", 64'(v1), 3'b100);
    check("t4_ch2_data", data1[2], 64'h55);
    check("t4_cnt_kept", 64'(cnt1), 1);
    req1 = beat(2'd3, 64'h0);
    for (int i = 0; i < 253; i++) tick();
    check("t4_cnt254", 64'(cnt1), 254);
    for (int i = 0; i < 46; i++) tick();
    req1.tvalid = 1'b0;
    check("t4_cnt_sat", 64'(cnt1), 255);
    check("t4_err_sticky", 64'(err1), 1);

    // ---------------- random traffic with scoreboard on the two-channel instance
    n_cred = 0;
    n_pop = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      int h;
      bit acc;
      h = $urandom_range(0, 1);
      req0 = beat(2'(h), {$urandom, $urandom});
      req0.tvalid = 1'($urandom_range(0, 1));
      rdy0 = 2'($urandom_range(0, 3));
      #1;
      check("rnd_tready", 64'(rsp0.tready), 64'(q[h].size() < 4));
      acc = req0.tvalid && (q[h].size() < 4);
      for (int c = 0; c < 2; c++) begin
        check("rnd_valid", 64'(v0[c]), 64'(q[c].size() > 0));
        if (q[c].size() > 0) begin
          check("rnd_data", data0[c], q[c][0]);
          if (rdy0[c]) begin
            void'(q[c].pop_front());
            n_pop++;
          end
        end
      end
      if (acc) q[h].push_back(req0.t.data[63:0]);
      tick();
    end
    req0.tvalid = 1'b0;
    rdy0 = 2'b11;
    for (int cyc = 0; cyc < 6; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        check("drn_valid", 64'(v0[c]), 64'(q[c].size() > 0));
        if (q[c].size() > 0) begin
          check("drn_data", data0[c], q[c][0]);
          void'(q[c].pop_front());
          n_pop++;
        end
      end
      tick();
    end
    tick();
    check("rnd_credits", 64'(n_cred), CR ? 64'(n_pop) : 64'd0);

    // ---------------- reset with flits queued
    rdy0 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      req0 = beat(request, 64'hC0 + 64'(i));
      tick();
    end
    req0.tvalid = 1'b0;
    check("t6_queued", 64'(v0), 2'b01);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(v0), 0);
    check("t6_rst_data", data0[0], 0);
    check("t6_rst_err", 64'(err1), 0);
    check("t6_rst_cnt", 64'(cnt1), 0);
    tick();
    rst_n = 1'b1;
    rdy0 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_post_valid", 64'(v0), 0);
      check("t6_post_credit", 64'(cr0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
